// File: rtl/rvvi_retire_serializer.sv
`default_nettype none
// ============================================================================
// Module      : rvvi_retire_serializer
// Description : Buffers a multi-retire RVVI trace in program order and replays
//               it one retirement per cycle, flagging overflow and order gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module rvvi_retire_serializer #(
    parameter int ILEN   = 32,
    parameter int XLEN   = 64,
    parameter int RETIRE = 2,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [RETIRE-1:0]          in_valid,
    input  logic [RETIRE*ILEN-1:0]     in_insn,
    input  logic [RETIRE*XLEN-1:0]     in_pc,
    input  logic [RETIRE-1:0]          in_trap,
    input  logic [RETIRE*64-1:0]       in_order,
    output logic                       out_valid,
    output logic [ILEN-1:0]            out_insn,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_trap,
    output logic [63:0]                out_order,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow,
    output logic                       order_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH+1);

    logic [ILEN-1:0] r_mem_insn  [DEPTH];
    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic            r_mem_trap  [DEPTH];
    logic [63:0]     r_mem_order [DEPTH];

    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            r_have_prev;

    logic            w_pop;
    logic [c_CW-1:0] w_free;
    logic [c_CW-1:0] w_push_n;
    logic            w_drop;
    logic [RETIRE-1:0] w_wr_en;
    logic [c_AW-1:0] w_wr_addr [RETIRE];
    logic [63:0]     w_head_order;

    assign w_pop        = (r_count != '0);
    assign w_free       = c_CW'(DEPTH) - r_count + {{(c_CW-1){1'b0}}, w_pop};
    assign w_head_order = r_mem_order[r_rptr];
    assign occupancy    = r_count;

    // Compact valid slots oldest-first; slots beyond the free space are dropped.
    always_comb begin
        w_push_n = '0;
        w_drop   = 1'b0;
        for (int i = 0; i < RETIRE; i++) begin
            w_wr_en[i]   = 1'b0;
            w_wr_addr[i] = r_wptr + w_push_n[c_AW-1:0];
            if (in_valid[i] && !reset) begin
                if (w_push_n < w_free) begin
                    w_wr_en[i] = 1'b1;
                    w_push_n   = w_push_n + 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RETIRE; i++) begin
            if (w_wr_en[i]) begin
                r_mem_insn[w_wr_addr[i]]  <= in_insn[i*ILEN +: ILEN];
                r_mem_pc[w_wr_addr[i]]    <= in_pc[i*XLEN +: XLEN];
                r_mem_trap[w_wr_addr[i]]  <= in_trap[i];
                r_mem_order[w_wr_addr[i]] <= in_order[i*64 +: 64];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_have_prev <= 1'b0;
            out_valid   <= 1'b0;
            out_insn    <= '0;
            out_pc      <= '0;
            out_trap    <= 1'b0;
            out_order   <= '0;
            overflow    <= 1'b0;
            order_err   <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + w_push_n[c_AW-1:0];
            r_count <= r_count - {{(c_CW-1){1'b0}}, w_pop} + w_push_n;
            if (w_drop) begin
                overflow <= 1'b1;
            end
            out_valid <= w_pop;
            if (w_pop) begin
                out_insn    <= r_mem_insn[r_rptr];
                out_pc      <= r_mem_pc[r_rptr];
                out_trap    <= r_mem_trap[r_rptr];
                out_order   <= w_head_order;
                r_rptr      <= r_rptr + 1'b1;
                r_have_prev <= 1'b1;
                // out_order still holds the previously emitted order here.
                if (r_have_prev && (w_head_order != out_order + 64'd1)) begin
                    order_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvvi_retire_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvvi_retire_serializer
// Description : Directed bench with a queue scoreboard for the retire serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvvi_retire_serializer;

    localparam int ILEN   = 32;
    localparam int XLEN   = 64;
    localparam int RETIRE = 2;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH+1);

    logic                   clk = 1'b0;
    logic                   reset;
    logic [RETIRE-1:0]      in_valid;
    logic [RETIRE*ILEN-1:0] in_insn;
    logic [RETIRE*XLEN-1:0] in_pc;
    logic [RETIRE-1:0]      in_trap;
    logic [RETIRE*64-1:0]   in_order;
    logic                   out_valid;
    logic [ILEN-1:0]        out_insn;
    logic [XLEN-1:0]        out_pc;
    logic                   out_trap;
    logic [63:0]            out_order;
    logic [CW-1:0]          occupancy;
    logic                   overflow;
    logic                   order_err;

    rvvi_retire_serializer #(
        .ILEN(ILEN), .XLEN(XLEN), .RETIRE(RETIRE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_insn(in_insn), .in_pc(in_pc),
        .in_trap(in_trap), .in_order(in_order),
        .out_valid(out_valid), .out_insn(out_insn), .out_pc(out_pc),
        .out_trap(out_trap), .out_order(out_order),
        .occupancy(occupancy), .overflow(overflow), .order_err(order_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic            trap;
        logic [63:0]     order;
    } entry_t;

    entry_t q[$];
    entry_t exp_out;
    logic   exp_valid;
    logic   m_over, m_err, m_have;
    logic [63:0] m_prev;
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [63:0] order, input logic [ILEN-1:0] insn);
        in_valid[i]              = 1'b1;
        in_order[i*64 +: 64]     = order;
        in_insn[i*ILEN +: ILEN]  = insn;
        in_pc[i*XLEN +: XLEN]    = 64'h8000_0000 + (order << 2);
        in_trap[i]               = order[1];
    endtask

    task automatic clear_slots();
        in_valid = '0;
        in_insn  = '0;
        in_pc    = '0;
        in_trap  = '0;
        in_order = '0;
    endtask

    // Scoreboard update for the edge just taken, using the inputs held across it.
    task automatic model_edge();
        entry_t e;
        if (reset) begin
            q.delete();
            exp_valid = 1'b0;
            exp_out   = '{insn: '0, pc: '0, trap: 1'b0, order: '0};
            m_over = 1'b0; m_err = 1'b0; m_have = 1'b0; m_prev = '0;
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                if (m_have && (e.order != m_prev + 64'd1)) m_err = 1'b1;
                m_prev    = e.order;
                m_have    = 1'b1;
                exp_out   = e;
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            for (int i = 0; i < RETIRE; i++) begin
                if (in_valid[i]) begin
                    e.insn  = in_insn[i*ILEN +: ILEN];
                    e.pc    = in_pc[i*XLEN +: XLEN];
                    e.trap  = in_trap[i];
                    e.order = in_order[i*64 +: 64];
                    if (q.size() < DEPTH) q.push_back(e);
                    else m_over = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("out_order", out_order, exp_out.order);
        check("out_insn",  64'(out_insn), 64'(exp_out.insn));
        check("out_pc",    out_pc, exp_out.pc);
        check("out_trap",  64'(out_trap), 64'(exp_out.trap));
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("overflow",  64'(overflow), 64'(m_over));
        check("order_err", 64'(order_err), 64'(m_err));
    endtask

    task automatic drain();
        clear_slots();
        for (int n = 0; n < 4*DEPTH && q.size() > 0; n++) cycle();
        check("drain_empty", 64'(q.size()), 64'd0);
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_slots();
        cycle();
        cycle();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_order", out_order, 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        reset = 1'b0;

        // Single retire: slot 0, order 5.
        set_slot(0, 64'd5, 32'h0000_0013);
        cycle();
        check("single_not_yet", 64'(out_valid), 64'd0);
        clear_slots();
        cycle();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_order", out_order, 64'd5);
        check("single_insn",  64'(out_insn), 64'h13);
        drain();
        check("single_flags", {62'd0, overflow, order_err}, 64'd0);

        // Dual retire, orders 10..17.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_slot(0, 64'(10 + 2*c), 32'h1000 + 32'(c));
            set_slot(1, 64'(11 + 2*c), 32'h2000 + 32'(c));
            cycle();
        end
        drain();
        check("dual_order_err", 64'(order_err), 64'd0);
        check("dual_last_order", out_order, 64'd17);

        // Sparse slots: slot 1 only, then slot 0 only.
        do_reset();
        clear_slots(); set_slot(1, 64'd3, 32'h33);
        cycle();
        clear_slots(); set_slot(0, 64'd4, 32'h44);
        cycle();
        drain();
        check("sparse_order_err", 64'(order_err), 64'd0);
        check("sparse_last", out_order, 64'd4);

        // Overflow: both slots every cycle for 10 cycles.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            set_slot(0, 64'(2*c), 32'h5000 + 32'(c));
            set_slot(1, 64'(2*c + 1), 32'h6000 + 32'(c));
            cycle();
            check("ovf_bound", 64'(occupancy <= CW'(DEPTH)), 64'd1);
        end
        check("ovf_full", 64'(occupancy), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        drain();
        check("ovf_order_err", 64'(order_err), 64'd1);

        // Order wrap then gap.
        do_reset();
        clear_slots(); set_slot(0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h71);
        cycle();
        clear_slots(); set_slot(0, 64'd0, 32'h72);
        cycle();
        clear_slots();
        cycle();
        cycle();
        check("wrap_no_err", 64'(order_err), 64'd0);
        set_slot(0, 64'd2, 32'h73);
        cycle();
        clear_slots();
        cycle();
        check("gap_err", 64'(order_err), 64'd1);
        cycle();
        cycle();
        check("gap_sticky", 64'(order_err), 64'd1);

        // Reset with six entries buffered.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_slot(0, 64'(20 + 2*c), 32'h8000);
            set_slot(1, 64'(21 + 2*c), 32'h9000);
            cycle();
        end
        check("pre_reset_occ", 64'(occupancy), 64'd6);
        do_reset();
        check("post_reset_valid", 64'(out_valid), 64'd0);
        check("post_reset_occ", 64'(occupancy), 64'd0);
        check("post_reset_flags", {62'd0, overflow, order_err}, 64'd0);
        clear_slots();
        cycle();
        set_slot(0, 64'd100, 32'hA0);
        cycle();
        clear_slots();
        cycle();
        check("after_reset_order", out_order, 64'd100);
        check("after_reset_err", 64'(order_err), 64'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
